// File: rtl/uart_rx_32.sv
// uart_rx_32 - 8N1 UART receiver that packs 1..4 bytes into one 32-bit word.
//   Byte k of a word lands in bits [8k+7:8k], matching the uart_tx_32 lane order.
//   A word is complete after N bytes, where N is numData (0 or >4 means 4) as seen
//   when the first byte of that word is accepted.
//
// Ports
//   i_Clock       system clock
//   i_Reset       asynchronous, active-high reset
//   i_Rx_Serial   serial line, idle high (asynchronous, synchronised here)
//   CLKS_PER_BIT  clocks per bit, 4..4095
//   numData       bytes per word, 1..4 (0 or >4 -> 4)
//   o_Rx_DV       one-cycle strobe, o_Rx_Word valid
//   o_Rx_Word     assembled word, unused upper lanes zero; held until the next o_Rx_DV
//   o_Rx_Active   high from start-bit detect until the stop-bit sample
//   o_Frame_Err   one-cycle strobe, stop bit sampled low
//
// state   | meaning
// IDLE    | line idle, waiting for a low level; times out a stale partial word
// START   | waiting for mid start bit to confirm it (false start returns to IDLE)
// DATA    | sampling 8 data bits at mid-bit, LSB first
// STOP    | sampling the stop bit; commits the byte or flags a framing error
// CLEANUP | one-cycle gap carrying the DV / frame-error strobe
module uart_rx_32 #(
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_Serial,
  input  logic [11:0] CLKS_PER_BIT,
  input  logic [2:0]  numData,
  output logic        o_Rx_DV,
  output logic [31:0] o_Rx_Word,
  output logic        o_Rx_Active,
  output logic        o_Frame_Err
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

  localparam logic [31:0] TO_BITS = 32'(TIMEOUT_BITS);

  state_t      state, state_next;
  logic        rx_meta, rx_sync;
  logic [11:0] clk_count, clk_count_next;
  logic [2:0]  bit_index, bit_index_next;
  logic [7:0]  rx_byte, rx_byte_next;
  logic [1:0]  byte_index, byte_index_next;
  logic [2:0]  num_lat, num_lat_next;
  logic [31:0] word_acc, word_acc_next;
  logic [31:0] idle_count, idle_count_next;
  logic        rx_dv_next, frame_err_next, rx_active_next;
  logic [31:0] rx_word_next;

  logic [11:0] half;
  logic [2:0]  num_eff, num_cur;
  logic [31:0] word_with_byte, word_masked, timeout_limit;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_sync <= rx_meta;
    end
  end

  always_comb begin
    num_eff = (numData == 3'd0 || numData > 3'd4) ? 3'd4 : numData;
    // The word length is frozen once the first byte is in.
    num_cur = (byte_index == 2'd0) ? num_eff : num_lat;
    half    = (CLKS_PER_BIT - 12'd1) >> 1;
    word_with_byte = word_acc | ({24'd0, rx_byte} << {byte_index, 3'b000});
    word_masked = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(num_cur)) word_masked[8*k +: 8] = word_with_byte[8*k +: 8];
    end
    timeout_limit = TO_BITS * {20'd0, CLKS_PER_BIT};
  end

  always_comb begin
    state_next      = state;
    clk_count_next  = clk_count + 12'd1;
    bit_index_next  = bit_index;
    rx_byte_next    = rx_byte;
    byte_index_next = byte_index;
    num_lat_next    = num_lat;
    word_acc_next   = word_acc;
    idle_count_next = '0;
    rx_dv_next      = 1'b0;
    frame_err_next  = 1'b0;
    rx_active_next  = o_Rx_Active;
    rx_word_next    = o_Rx_Word;

    case (state)
      IDLE: begin
        clk_count_next = '0;
        if (!rx_sync) begin
          state_next     = START;
          rx_active_next = 1'b1;
        end else if (TIMEOUT_BITS != 0 && byte_index != 2'd0) begin
          if (idle_count == timeout_limit - 32'd1) begin
            word_acc_next   = '0;
            byte_index_next = '0;
          end else begin
            idle_count_next = idle_count + 32'd1;
          end
        end
      end
      START: begin
        if (clk_count == half) begin
          clk_count_next = '0;
          if (!rx_sync) begin
            state_next     = DATA;
            bit_index_next = '0;
          end else begin
            state_next     = IDLE;
            rx_active_next = 1'b0;
          end
        end
      end
      DATA: begin
        if (clk_count == CLKS_PER_BIT - 12'd1) begin
          clk_count_next = '0;
          rx_byte_next   = {rx_sync, rx_byte[7:1]};
          if (bit_index == 3'd7) state_next = STOP;
          else bit_index_next = bit_index + 3'd1;
        end
      end
      STOP: begin
        if (clk_count == CLKS_PER_BIT - 12'd1) begin
          clk_count_next = '0;
          state_next     = CLEANUP;
          rx_active_next = 1'b0;
          // Strobes and word updates are registered here so they appear during CLEANUP.
          if (rx_sync) begin
            if (byte_index == 2'd0) num_lat_next = num_eff;
            if ({1'b0, byte_index} == num_cur - 3'd1) begin
              rx_dv_next      = 1'b1;
              rx_word_next    = word_masked;
              word_acc_next   = '0;
              byte_index_next = '0;
            end else begin
              word_acc_next   = word_with_byte;
              byte_index_next = byte_index + 2'd1;
            end
          end else begin
            frame_err_next  = 1'b1;
            word_acc_next   = '0;
            byte_index_next = '0;
          end
        end
      end
      CLEANUP: begin
        clk_count_next = '0;
        state_next     = IDLE;
      end
      default: begin
        clk_count_next = '0;
        state_next     = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= IDLE;
      clk_count   <= '0;
      bit_index   <= '0;
      rx_byte     <= '0;
      byte_index  <= '0;
      num_lat     <= 3'd4;
      word_acc    <= '0;
      idle_count  <= '0;
      o_Rx_DV     <= 1'b0;
      o_Rx_Word   <= '0;
      o_Rx_Active <= 1'b0;
      o_Frame_Err <= 1'b0;
    end else begin
      state       <= state_next;
      clk_count   <= clk_count_next;
      bit_index   <= bit_index_next;
      rx_byte     <= rx_byte_next;
      byte_index  <= byte_index_next;
      num_lat     <= num_lat_next;
      word_acc    <= word_acc_next;
      idle_count  <= idle_count_next;
      o_Rx_DV     <= rx_dv_next;
      o_Rx_Word   <= rx_word_next;
      o_Rx_Active <= rx_active_next;
      o_Frame_Err <= frame_err_next;
    end
  end

endmodule

// File: tb/tb_uart_rx_32.sv
// tb_uart_rx_32 - directed scenarios plus randomized traffic checked against a
// byte-queue reference model of the word packing rules.
module tb_uart_rx_32;
  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic        i_Rx_Serial;
  logic [11:0] CLKS_PER_BIT;
  logic [2:0]  numData;
  logic        o_Rx_DV;
  logic [31:0] o_Rx_Word;
  logic        o_Rx_Active;
  logic        o_Frame_Err;

  uart_rx_32 #(.TIMEOUT_BITS(40)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_Serial(i_Rx_Serial),
    .CLKS_PER_BIT(CLKS_PER_BIT), .numData(numData),
    .o_Rx_DV(o_Rx_DV), .o_Rx_Word(o_Rx_Word),
    .o_Rx_Active(o_Rx_Active), .o_Frame_Err(o_Frame_Err)
  );

  always #5 i_Clock = ~i_Clock;

  int checks = 0;
  int errors = 0;
  int cpb = 87;

  // observed activity
  logic [31:0] obs_words[$];
  int ferr_cnt = 0, both_cnt = 0, dv_long = 0;
  logic dv_prev = 1'b0;

  // reference model
  logic [31:0] exp_words[$];
  logic [7:0]  partial[$];
  int exp_ferr = 0;
  int n_lat = 4;

  always @(negedge i_Clock) begin
    if (o_Rx_DV) obs_words.push_back(o_Rx_Word);
    if (o_Rx_DV && dv_prev) dv_long++;
    if (o_Frame_Err) ferr_cnt++;
    if (o_Rx_DV && o_Frame_Err) both_cnt++;
    dv_prev = o_Rx_DV;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_Clock);
    #1;
  endtask

  function automatic int eff_n(input logic [2:0] nd);
    return (nd == 0 || nd > 4) ? 4 : int'(nd);
  endfunction

  function automatic void model_byte(input logic [7:0] b, input logic stop_ok);
    logic [31:0] w;
    if (!stop_ok) begin
      partial.delete();
      exp_ferr++;
      return;
    end
    if (partial.size() == 0) n_lat = eff_n(numData);
    partial.push_back(b);
    if (partial.size() == n_lat) begin
      w = '0;
      foreach (partial[i]) w = w | (32'(partial[i]) << (8 * i));
      exp_words.push_back(w);
      partial.delete();
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    i_Rx_Serial = 1'b0;
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      i_Rx_Serial = b[i];
      tick(cpb);
    end
    i_Rx_Serial = stop_ok;
    tick(cpb);
    i_Rx_Serial = 1'b1;
    model_byte(b, stop_ok);
  endtask

  task automatic apply_reset();
    CLKS_PER_BIT = cpb[11:0];
    i_Rx_Serial  = 1'b1;
    i_Reset      = 1'b1;
    tick(3);
    i_Reset = 1'b0;
    tick(3);
    obs_words.delete();
    exp_words.delete();
    partial.delete();
    ferr_cnt = 0; both_cnt = 0; dv_long = 0; exp_ferr = 0;
  endtask

  task automatic test_reset();
    cpb = 87;
    CLKS_PER_BIT = 12'd87;
    numData = 3'd4;
    i_Rx_Serial = 1'b1;
    i_Reset = 1'b1;
    #1;
    checks++; if (o_Rx_DV !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", o_Rx_DV); end
    checks++; if (o_Rx_Word !== 32'h0) begin errors++; $display("FAIL reset_word got %h want 00000000", o_Rx_Word); end
    checks++; if (o_Rx_Active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", o_Rx_Active); end
    checks++; if (o_Frame_Err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", o_Frame_Err); end
    apply_reset();
  endtask

  task automatic test_four_bytes();
    cpb = 87; numData = 3'd4;
    apply_reset();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    checks++; if (obs_words.size() !== 1) begin errors++; $display("FAIL t1_dv_latency got %0d words want 1 by end of stop bit", obs_words.size()); end
    tick(2 * cpb);
    checks++; if (obs_words.size() !== 1) begin errors++; $display("FAIL t1_dv_count got %0d want 1", obs_words.size()); end
    checks++; if (obs_words[0] !== 32'h44332211) begin errors++; $display("FAIL t1_word got %h want 44332211", obs_words[0]); end
    checks++; if (o_Rx_Word !== 32'h44332211) begin errors++; $display("FAIL t1_word_hold got %h want 44332211", o_Rx_Word); end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL t1_ferr got %0d want 0", ferr_cnt); end
    checks++; if (dv_long !== 0) begin errors++; $display("FAIL t1_dv_width got %0d extra cycles want 0", dv_long); end
  endtask

  task automatic test_single();
    cpb = 87; numData = 3'd1;
    apply_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    tick(2 * cpb);
    checks++; if (obs_words.size() !== 2) begin errors++; $display("FAIL t2_dv_count got %0d want 2", obs_words.size()); end
    checks++; if (obs_words[0] !== 32'h000000A5) begin errors++; $display("FAIL t2_word0 got %h want 000000a5", obs_words[0]); end
    checks++; if (obs_words[1] !== 32'h0000003C) begin errors++; $display("FAIL t2_word1 got %h want 0000003c", obs_words[1]); end
  endtask

  task automatic test_numdata_change();
    cpb = 87; numData = 3'd3;
    apply_reset();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    tick(cpb);
    checks++; if (obs_words[0] !== 32'h00030201) begin errors++; $display("FAIL t3_word0 got %h want 00030201", obs_words[0]); end
    send_byte(8'h0A, 1'b1);
    numData = 3'd2;
    send_byte(8'h0B, 1'b1);
    tick(2 * cpb);
    checks++; if (obs_words.size() !== 1) begin errors++; $display("FAIL t3_no_early_dv got %0d words want 1", obs_words.size()); end
    send_byte(8'h0C, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    tick(2 * cpb);
    checks++; if (obs_words.size() !== 3) begin errors++; $display("FAIL t3_dv_count got %0d want 3", obs_words.size()); end
    checks++; if (obs_words[1] !== 32'h000C0B0A) begin errors++; $display("FAIL t3_word1 got %h want 000c0b0a", obs_words[1]); end
    checks++; if (obs_words[2] !== 32'h00006655) begin errors++; $display("FAIL t3_word2 got %h want 00006655", obs_words[2]); end
  endtask

  task automatic test_frame_err();
    cpb = 87; numData = 3'd4;
    apply_reset();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h77, 1'b0);
    tick(2 * cpb);
    checks++; if (ferr_cnt !== 1) begin errors++; $display("FAIL t4_ferr_pulse got %0d cycles want 1", ferr_cnt); end
    checks++; if (obs_words.size() !== 0) begin errors++; $display("FAIL t4_no_dv got %0d want 0", obs_words.size()); end
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    tick(2 * cpb);
    checks++; if (obs_words.size() !== 1) begin errors++; $display("FAIL t4_dv_count got %0d want 1", obs_words.size()); end
    checks++; if (obs_words[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL t4_word got %h want deadbeef", obs_words[0]); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL t4_dv_ferr_overlap got %0d want 0", both_cnt); end
  endtask

  task automatic test_glitch();
    cpb = 87; numData = 3'd1;
    apply_reset();
    i_Rx_Serial = 1'b0;
    tick(10);
    checks++; if (o_Rx_Active !== 1'b1) begin errors++; $display("FAIL t5_active_on got %b want 1", o_Rx_Active); end
    tick(10);
    i_Rx_Serial = 1'b1;
    tick(40);
    checks++; if (o_Rx_Active !== 1'b0) begin errors++; $display("FAIL t5_active_off got %b want 0", o_Rx_Active); end
    tick(2 * cpb);
    checks++; if (obs_words.size() !== 0 || ferr_cnt !== 0) begin errors++; $display("FAIL t5_no_strobe got dv %0d ferr %0d want 0 0", obs_words.size(), ferr_cnt); end
    send_byte(8'h5A, 1'b1);
    tick(2 * cpb);
    checks++; if (obs_words[0] !== 32'h0000005A) begin errors++; $display("FAIL t5_after_glitch got %h want 0000005a", obs_words[0]); end
  endtask

  task automatic test_timeout();
    cpb = 87; numData = 3'd4;
    apply_reset();
    send_byte(8'h99, 1'b1);
    send_byte(8'h88, 1'b1);
    tick(40 * cpb + cpb);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    tick(2 * cpb);
    checks++; if (obs_words.size() !== 1) begin errors++; $display("FAIL t6_dv_count got %0d want 1", obs_words.size()); end
    checks++; if (obs_words[0] !== 32'h04030201) begin errors++; $display("FAIL t6_word got %h want 04030201", obs_words[0]); end
  endtask

  task automatic test_reset_mid();
    cpb = 87; numData = 3'd4;
    apply_reset();
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'hD4, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    i_Rx_Serial = 1'b0;
    tick(cpb);
    i_Rx_Serial = 1'b1;
    tick(3 * cpb);
    i_Reset = 1'b1;
    #1;
    checks++; if (o_Rx_Word !== 32'h0 || o_Rx_DV !== 1'b0) begin errors++; $display("FAIL t7_reset_word got %h dv %b want 00000000 0", o_Rx_Word, o_Rx_DV); end
    checks++; if (o_Rx_Active !== 1'b0 || o_Frame_Err !== 1'b0) begin errors++; $display("FAIL t7_reset_flags got active %b ferr %b want 0 0", o_Rx_Active, o_Frame_Err); end
    tick(2);
    i_Reset = 1'b0;
    tick(3 * cpb);
    obs_words.delete();
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    tick(2 * cpb);
    checks++; if (obs_words.size() !== 1) begin errors++; $display("FAIL t7_dv_count got %0d want 1", obs_words.size()); end
    checks++; if (obs_words[0] !== 32'h12345678) begin errors++; $display("FAIL t7_word got %h want 12345678", obs_words[0]); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      cpb = int'($urandom_range(4, 40));
      numData = 3'd4;
      apply_reset();
      for (int n = 0; n < 14; n++) begin
        logic [7:0] b;
        logic ok;
        b = 8'($urandom);
        ok = ($urandom_range(0, 7) != 0);
        numData = 3'($urandom_range(0, 7));
        send_byte(b, ok);
        if (!ok) tick(2 * cpb);
        else tick(int'($urandom_range(0, 2)) * cpb);
      end
      tick(3 * cpb);
      checks++; if (obs_words.size() !== exp_words.size()) begin errors++; $display("FAIL rnd%0d_dv_count got %0d want %0d", r, obs_words.size(), exp_words.size()); end
      foreach (exp_words[i]) begin
        checks++;
        if (obs_words[i] !== exp_words[i]) begin errors++; $display("FAIL rnd%0d_word%0d got %h want %h", r, i, obs_words[i], exp_words[i]); end
      end
      checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("FAIL rnd%0d_ferr got %0d want %0d", r, ferr_cnt, exp_ferr); end
      checks++; if (both_cnt !== 0 || dv_long !== 0) begin errors++; $display("FAIL rnd%0d_strobes got overlap %0d long %0d want 0 0", r, both_cnt, dv_long); end
    end
  endtask

  initial begin
    test_reset();
    test_four_bytes();
    test_single();
    test_numdata_change();
    test_frame_err();
    test_glitch();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
